// File: rtl/alu_seq_if.sv
// Command channel between a host (or harness) and the multi-byte ALU sequencer.
// The host drives the command; the sequencer returns busy/done and the final carry.
interface alu_seq_if #(
    parameter int AW = 8,
    parameter int LW = 8
);
    logic          start;
    logic [2:0]    cmd_op;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] cmd_a;
    logic [AW-1:0] cmd_b;
    logic [AW-1:0] cmd_d;
    logic          busy;
    logic          done;
    logic          cy_out;

    modport master (
        output start, cmd_op, cmd_len,
        output cmd_a, cmd_b, cmd_d,
        input  busy, done, cy_out
    );

    modport slave (
        input  start, cmd_op, cmd_len,
        input  cmd_a, cmd_b, cmd_d,
        output busy, done, cy_out
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-byte sequencer: walks operand RAM LSB first and drives an 8-bit ALU
// with carry chaining, writing each result byte back to RAM.
module alu_seq #(
    parameter int AW = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_if.slave      cmd,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [7:0]    mem_rdata,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    output logic [2:0]    alu_op,
    output logic          alu_ce_cy,
    output logic [7:0]    alu_in_a,
    output logic [7:0]    alu_in_r,
    input  logic [7:0]    alu_result,
    input  logic          alu_cy
);

    localparam logic [2:0] OP_CLR = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        CLRC,
        RDA,
        RDB,
        LATB,
        EXEC,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [2:0]    op_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx;
    logic [AW-1:0] a_q;
    logic [AW-1:0] b_q;
    logic [AW-1:0] d_q;
    logic [AW-1:0] idx_w;
    logic [7:0]    in_a_q;
    logic [7:0]    in_r_q;
    logic          cy_q;
    logic          last;

    assign idx_w = AW'(idx);
    assign last  = (idx == len_q - LW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            len_q  <= '0;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            in_a_q <= '0;
            in_r_q <= '0;
            cy_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (cmd.start && cmd.cmd_len != '0) begin
                        op_q  <= cmd.cmd_op;
                        len_q <= cmd.cmd_len;
                        a_q   <= cmd.cmd_a;
                        b_q   <= cmd.cmd_b;
                        d_q   <= cmd.cmd_d;
                        idx   <= '0;
                    end
                end
                RDB:  in_a_q <= mem_rdata;
                LATB: in_r_q <= mem_rdata;
                EXEC: begin
                    if (!last) idx <= idx + LW'(1);
                end
                DONE: cy_q <= alu_cy;
                default: ;
            endcase
        end
    end

    // The ALU op stays on the captured code from RDA through EXEC so the
    // carry register only moves when alu_ce_cy is asserted.
    always_comb begin
        state_nx  = state;
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        alu_op    = OP_CLR;
        alu_ce_cy = 1'b0;
        case (state)
            IDLE: begin
                if (cmd.start) begin
                    state_nx = (cmd.cmd_len != '0) ? CLRC : DONE;
                end
            end
            CLRC: begin
                alu_ce_cy = 1'b1;
                state_nx  = RDA;
            end
            RDA: begin
                alu_op   = op_q;
                mem_addr = a_q + idx_w;
                mem_re   = 1'b1;
                state_nx = RDB;
            end
            RDB: begin
                alu_op   = op_q;
                mem_addr = b_q + idx_w;
                mem_re   = 1'b1;
                state_nx = LATB;
            end
            LATB: begin
                alu_op   = op_q;
                state_nx = EXEC;
            end
            EXEC: begin
                alu_op    = op_q;
                alu_ce_cy = 1'b1;
                mem_addr  = d_q + idx_w;
                mem_we    = 1'b1;
                state_nx  = last ? DONE : RDA;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_wdata  = alu_result;
    assign alu_in_a   = in_a_q;
    assign alu_in_r   = in_r_q;
    assign cmd.busy   = (state != IDLE);
    assign cmd.done   = (state == DONE);
    assign cmd.cy_out = cy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU and a 256-byte RAM.
// Each task drives one scenario and checks hand-computed results inline.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mem_addr;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [2:0] alu_op;
    logic       alu_ce_cy;
    logic [7:0] alu_in_a;
    logic [7:0] alu_in_r;
    logic [7:0] alu_result;
    logic       alu_cy;

    int pass_cnt = 0;
    int total    = 0;

    alu_seq_if #(.AW(8), .LW(8)) cmd ();

    alu_seq #(.AW(8), .LW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .alu_op     (alu_op),
        .alu_ce_cy  (alu_ce_cy),
        .alu_in_a   (alu_in_a),
        .alu_in_r   (alu_in_r),
        .alu_result (alu_result),
        .alu_cy     (alu_cy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 000 add, 001 sub with borrow, 101 not, else pass.
    logic       cy_r = 1'b0;
    logic       cy_nx;
    logic [8:0] t9;

    always_comb begin
        t9    = '0;
        cy_nx = 1'b0;
        alu_result = alu_in_a;
        case (alu_op)
            3'b000: begin
                t9 = {1'b0, alu_in_a} + {1'b0, alu_in_r} + {8'd0, cy_r};
                alu_result = t9[7:0];
                cy_nx = t9[8];
            end
            3'b001: begin
                t9 = {1'b0, alu_in_a} - {1'b0, alu_in_r} - {8'd0, cy_r};
                alu_result = t9[7:0];
                cy_nx = t9[8];
            end
            3'b101: alu_result = ~alu_in_a;
            default: ;
        endcase
    end

    assign alu_cy = cy_r;

    always @(posedge clk) begin
        if (alu_ce_cy) cy_r <= cy_nx;
    end

    // RAM with a bench-side write port used for preloading.
    logic [7:0] ram [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = '0;
    logic [7:0] tb_wdata = '0;
    int         re_cnt = 0;
    int         we_cnt = 0;
    logic [7:0] rd_log [$];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (tb_we) ram[tb_addr] <= tb_wdata;
        if (mem_re) begin
            mem_rdata <= ram[mem_addr];
            rd_log.push_back(mem_addr);
            re_cnt <= re_cnt + 1;
        end
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        tb_we = 1'b1;
        tb_addr = a;
        tb_wdata = v;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] len,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] d);
        @(negedge clk);
        cmd.start   = 1'b1;
        cmd.cmd_op  = op;
        cmd.cmd_len = len;
        cmd.cmd_a   = a;
        cmd.cmd_b   = b;
        cmd.cmd_d   = d;
        @(posedge clk);
        #1 cmd.start = 1'b0;
    endtask

    // Latency k means done seen at the k-th negedge after the accept edge.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] len,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] d, output int lat);
        issue(op, len, a, b, d);
        lat = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (cmd.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (cmd.busy !== 1'b0 || cmd.done !== 1'b0 || cmd.cy_out !== 1'b0)
            $display("FAIL reset_status: got %b%b%b want 000",
                     cmd.busy, cmd.done, cmd.cy_out);
        else pass_cnt++;
        total++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0 || alu_ce_cy !== 1'b0)
            $display("FAIL reset_strobes: got %b%b%b want 000",
                     mem_re, mem_we, alu_ce_cy);
        else pass_cnt++;
        total++;
        if (alu_op !== 3'b110)
            $display("FAIL reset_alu_op: got %b want 110", alu_op);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add16();
        int lat;
        poke(8'h00, 8'hFF);
        poke(8'h01, 8'h12);
        poke(8'h02, 8'h01);
        poke(8'h03, 8'h00);
        run_cmd(3'b000, 8'd2, 8'h00, 8'h02, 8'h04, lat);
        total++;
        if (lat !== 10) $display("FAIL add16_latency: got %0d want 10", lat);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if ({ram[5], ram[4]} !== 16'h1300)
            $display("FAIL add16_result: got %h want 1300", {ram[5], ram[4]});
        else pass_cnt++;
        total++;
        if (cmd.cy_out !== 1'b0)
            $display("FAIL add16_cy: got %b want 0", cmd.cy_out);
        else pass_cnt++;
        total++;
        if (cmd.busy !== 1'b0)
            $display("FAIL add16_idle: got busy %b want 0", cmd.busy);
        else pass_cnt++;
    endtask

    task automatic test_carry_clear();
        int lat;
        poke(8'h08, 8'hFF);
        poke(8'h09, 8'h01);
        run_cmd(3'b000, 8'd1, 8'h08, 8'h09, 8'h0A, lat);
        @(posedge clk);
        #1;
        total++;
        if (lat !== 6 || ram[8'h0A] !== 8'h00 || cmd.cy_out !== 1'b1)
            $display("FAIL carry_out: got lat %0d res %h cy %b want 6 00 1",
                     lat, ram[8'h0A], cmd.cy_out);
        else pass_cnt++;
        poke(8'h08, 8'h01);
        run_cmd(3'b000, 8'd1, 8'h08, 8'h09, 8'h0B, lat);
        @(posedge clk);
        #1;
        total++;
        if (ram[8'h0B] !== 8'h02)
            $display("FAIL carry_preclear: got %h want 02", ram[8'h0B]);
        else pass_cnt++;
        total++;
        if (cmd.cy_out !== 1'b0)
            $display("FAIL carry_cy2: got %b want 0", cmd.cy_out);
        else pass_cnt++;
    endtask

    task automatic test_sub16();
        int lat;
        poke(8'h10, 8'h00);
        poke(8'h11, 8'h00);
        poke(8'h12, 8'h01);
        poke(8'h13, 8'h00);
        run_cmd(3'b001, 8'd2, 8'h10, 8'h12, 8'h14, lat);
        @(posedge clk);
        #1;
        total++;
        if ({ram[8'h15], ram[8'h14]} !== 16'hFFFF || cmd.cy_out !== 1'b1)
            $display("FAIL sub_borrow: got %h cy %b want ffff 1",
                     {ram[8'h15], ram[8'h14]}, cmd.cy_out);
        else pass_cnt++;
        poke(8'h11, 8'h01);
        run_cmd(3'b001, 8'd2, 8'h10, 8'h12, 8'h14, lat);
        @(posedge clk);
        #1;
        total++;
        if ({ram[8'h15], ram[8'h14]} !== 16'h00FF || cmd.cy_out !== 1'b0)
            $display("FAIL sub_noborrow: got %h cy %b want 00ff 0",
                     {ram[8'h15], ram[8'h14]}, cmd.cy_out);
        else pass_cnt++;
    endtask

    task automatic test_len_zero();
        int lat;
        int re0;
        int we0;
        re0 = re_cnt;
        we0 = we_cnt;
        run_cmd(3'b000, 8'd0, 8'h00, 8'h02, 8'h04, lat);
        total++;
        if (lat !== 1) $display("FAIL len0_latency: got %0d want 1", lat);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (re_cnt !== re0 || we_cnt !== we0)
            $display("FAIL len0_noaccess: got re %0d we %0d want %0d %0d",
                     re_cnt, we_cnt, re0, we0);
        else pass_cnt++;
        total++;
        if (cmd.cy_out !== 1'b0 || cmd.busy !== 1'b0)
            $display("FAIL len0_status: got cy %b busy %b want 0 0",
                     cmd.cy_out, cmd.busy);
        else pass_cnt++;
    endtask

    task automatic test_addr_wrap();
        int lat;
        int base;
        poke(8'hFF, 8'h34);
        poke(8'h00, 8'h12);
        poke(8'h70, 8'h01);
        poke(8'h71, 8'h00);
        base = rd_log.size();
        run_cmd(3'b000, 8'd2, 8'hFF, 8'h70, 8'h80, lat);
        @(posedge clk);
        #1;
        total++;
        if (rd_log.size() != base + 4)
            $display("FAIL wrap_nreads: got %0d want 4", rd_log.size() - base);
        else if (rd_log[base] !== 8'hFF || rd_log[base+1] !== 8'h70 ||
                 rd_log[base+2] !== 8'h00 || rd_log[base+3] !== 8'h71)
            $display("FAIL wrap_addrs: got %h %h %h %h want ff 70 00 71",
                     rd_log[base], rd_log[base+1],
                     rd_log[base+2], rd_log[base+3]);
        else pass_cnt++;
        total++;
        if ({ram[8'h81], ram[8'h80]} !== 16'h1235)
            $display("FAIL wrap_result: got %h want 1235",
                     {ram[8'h81], ram[8'h80]});
        else pass_cnt++;
    endtask

    task automatic test_in_place();
        int lat;
        poke(8'h90, 8'h0F);
        poke(8'h91, 8'hA5);
        poke(8'h92, 8'h33);
        poke(8'h93, 8'h44);
        run_cmd(3'b101, 8'd2, 8'h90, 8'h92, 8'h90, lat);
        @(posedge clk);
        #1;
        total++;
        if ({ram[8'h91], ram[8'h90]} !== 16'h5AF0 || lat !== 10)
            $display("FAIL inplace_not: got %h lat %0d want 5af0 10",
                     {ram[8'h91], ram[8'h90]}, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int  lat;
        logic bsy_ok;
        poke(8'h20, 8'hFF);
        poke(8'h21, 8'hFF);
        poke(8'h22, 8'h01);
        poke(8'h30, 8'h01);
        poke(8'h31, 8'h00);
        poke(8'h32, 8'h00);
        poke(8'h50, 8'h5A);
        issue(3'b000, 8'd3, 8'h20, 8'h30, 8'h40);
        lat = 0;
        bsy_ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (cmd.done) begin
                lat = k;
                break;
            end
            if (cmd.busy !== 1'b1) bsy_ok = 1'b0;
            if (k == 5) begin
                cmd.start   = 1'b1;
                cmd.cmd_op  = 3'b101;
                cmd.cmd_len = 8'd1;
                cmd.cmd_a   = 8'h50;
                cmd.cmd_b   = 8'h50;
                cmd.cmd_d   = 8'h50;
            end else begin
                cmd.start = 1'b0;
            end
        end
        cmd.start = 1'b0;
        total++;
        if (lat !== 14 || bsy_ok !== 1'b1)
            $display("FAIL b2b_timing: got lat %0d busy_ok %b want 14 1",
                     lat, bsy_ok);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total++;
        if ({ram[8'h42], ram[8'h41], ram[8'h40]} !== 24'h020000)
            $display("FAIL b2b_result: got %h want 020000",
                     {ram[8'h42], ram[8'h41], ram[8'h40]});
        else pass_cnt++;
        total++;
        if (cmd.busy !== 1'b0 || ram[8'h50] !== 8'h5A)
            $display("FAIL b2b_ignored: got busy %b ram50 %h want 0 5a",
                     cmd.busy, ram[8'h50]);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int lat;
        poke(8'h60, 8'h11);
        poke(8'h61, 8'h22);
        poke(8'h62, 8'h01);
        poke(8'h63, 8'h02);
        poke(8'h64, 8'hAA);
        poke(8'h65, 8'hBB);
        issue(3'b000, 8'd2, 8'h60, 8'h62, 8'h64);
        repeat (7) @(negedge clk);
        total++;
        if (mem_re !== 1'b1 || mem_addr !== 8'h63)
            $display("FAIL rst_rdb1: got re %b addr %h want 1 63",
                     mem_re, mem_addr);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total++;
        if (cmd.busy !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0)
            $display("FAIL rst_async: got busy %b we %b re %b want 000",
                     cmd.busy, mem_we, mem_re);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (ram[8'h64] !== 8'h12 || ram[8'h65] !== 8'hBB)
            $display("FAIL rst_partial: got %h %h want 12 bb",
                     ram[8'h64], ram[8'h65]);
        else pass_cnt++;
        run_cmd(3'b000, 8'd1, 8'h61, 8'h63, 8'h66, lat);
        @(posedge clk);
        #1;
        total++;
        if (lat !== 6 || ram[8'h66] !== 8'h24 || cmd.cy_out !== 1'b0)
            $display("FAIL rst_recover: got lat %0d res %h cy %b want 6 24 0",
                     lat, ram[8'h66], cmd.cy_out);
        else pass_cnt++;
    endtask

    initial begin
        cmd.start   = 1'b0;
        cmd.cmd_op  = '0;
        cmd.cmd_len = '0;
        cmd.cmd_a   = '0;
        cmd.cmd_b   = '0;
        cmd.cmd_d   = '0;
        test_reset();
        test_add16();
        test_carry_clear();
        test_sub16();
        test_len_zero();
        test_addr_wrap();
        test_in_place();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Multi-byte operation sequencer that drives the 8-bit ALU (alu module) over operands held in a byte-wide operand RAM.
- On a start command it clears the ALU carry, then for each byte, LSB first: reads A and B, executes the ALU op with carry chaining, and writes the result.
- Reports final carry/borrow and a done pulse.
- Sits between the command source (test harness or host FSM) and the ALU plus RAM pair.

Parameters:
AW, 8, operand RAM address width; all address arithmetic wraps modulo 2^AW.
LW, 8, byte-count width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe; accepted only in IDLE
cmd_op  in  3  ALU op code (same encoding as alu.op), captured on accept
cmd_len  in  LW  byte count N, captured on accept
cmd_a  in  AW  base address of operand A
cmd_b  in  AW  base address of operand B
cmd_d  in  AW  base address of destination
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of command
cy_out  out  1  final ALU carry/borrow, registered; held until next done
mem_addr  out  AW  RAM address
mem_re  out  1  RAM read enable; synchronous read, rd_data valid next cycle
mem_rdata  in  8  RAM read data
mem_we  out  1  RAM write enable
mem_wdata  out  8  RAM write data (= alu_result)
alu_op  out  3  to alu.op
alu_ce_cy  out  1  to alu.ce_cy
alu_in_a  out  8  to alu.in_a, registered operand A
alu_in_r  out  8  to alu.in_r, registered operand B
alu_result  in  8  from alu.result
alu_cy  in  1  from alu.cy

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy, done, cy_out, mem_re, mem_we, alu_ce_cy = 0; alu_op = 3'b110; operand registers, index, and captured command = 0. Outputs go low immediately, not at the next edge.
- Reset asserted mid-command: abandons the command with no further writes. Bytes already written stay written.
- FSM states: IDLE, CLRC, RDA, RDB, LATB, EXEC, DONE.
- IDLE:
  - start=1 with cmd_len!=0: capture cmd_*, idx=0, go to CLRC.
  - start=1 with cmd_len==0: go to DONE directly. No RAM or ALU activity; cy_out reloads from current alu_cy.
- CLRC: alu_op=3'b110, alu_ce_cy=1 for one cycle. The ALU carry clears to 0. Go to RDA.
- RDA: mem_addr=a+idx, mem_re=1. Go to RDB.
- RDB: mem_addr=b+idx, mem_re=1. At the clock edge, alu_in_a <= mem_rdata (A byte). Go to LATB.
- LATB: at the clock edge, alu_in_r <= mem_rdata (B byte). Go to EXEC.
- EXEC:
  - alu_op=captured op, alu_ce_cy=1, mem_addr=d+idx, mem_we=1, mem_wdata=alu_result.
  - The carry updates at the end of this cycle.
  - If idx==N-1, go to DONE; else idx<=idx+1, go to RDA.
- DONE: done=1, cy_out<=alu_cy (final carry for add, borrow for sub, 0 for logic/pass). Go to IDLE.
- alu_op holds the captured op in RDA, RDB, LATB and EXEC. alu_ce_cy is high only in CLRC and EXEC. The carry therefore chains byte to byte unchanged.
- Latency: start accepted at edge T. done is high in cycle T+1+1+4N, i.e. busy for 4N+2 cycles including DONE. For N=0: done in cycle T+1.
- Address wrap: a+idx, b+idx, d+idx are computed modulo 2^AW.
- Overlapping regions (d==a or d==b) are legal. Byte i is read before byte i is written, so in-place ops are correct.
- start while busy: ignored, with no effect on captured command or state.
- start in the same cycle as DONE: ignored. The next start is accepted in IDLE.
- All ops, including unary NOT (3'b101), always read B; cycle count is op-independent.
- Max N = 2^LW-1. idx is LW bits wide.

Test Plan:
1. 16-bit add: RAM[0..1]=FF,12; RAM[2..3]=01,00; start op=000,len=2,a=0,b=2,d=4 -> RAM[4..5]=00,13; cy_out=0; done exactly 10 cycles after start edge.
2. Carry-out and pre-clear: first a 1-byte add FF+01 leaves alu_cy=1. Then 1-byte add 01+01 -> result 02, not 03. cy_out=1 after the first command, 0 after the second.
3. 16-bit subtract: A=0x0000, B=0x0001, op=001 -> D=0xFFFF, cy_out=1 (borrow). Also A=0x0100, B=0x0001 -> D=0x00FF, cy_out=0.
4. Boundaries:
   - len=0: done 1 cycle after start; mem_re and mem_we never assert.
   - a=0xFF, len=2: reads addresses FF then 00.
   - In-place: d=a with op=101 inverts bytes correctly.
5. start pulsed during EXEC of a 3-byte command -> ignored; command finishes unchanged; busy stays high throughout.
6. rst_n low during RDB of byte 1 of 2 -> busy, mem_we, mem_re go 0 asynchronously. Byte 0 written, byte 1 not. After release, a new command runs normally from IDLE.
